async_fifo: RTL and testbench

- Dual-clock FIFO that carries DATA_WIDTH-bit words from a producer clock domain (in_clock) to a consumer clock domain (out_clock).
- Both sides use a ready/valid handshake.
- Gray-coded pointers cross between the domains through 2-flop synchronisers.
- Used wherever a byte or word stream must move between unrelated clocks, e.g. a peripheral clock and the core clock.

---
 rtl/async_fifo.sv | 106 ++++++++++
 tb/tb_async_fifo.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/async_fifo.sv
// rtl/async_fifo.sv - dual-clock FIFO with Gray-coded pointers and 2-flop synchronisers
// Registered full/empty and almost flags are each computed in their own clock domain.
module async_fifo #(
  parameter int DATA_WIDTH       = 8,
  parameter int ADDR_WIDTH       = 4,
  parameter int ALMOST_THRESHOLD = 2
) (
  input  logic                  in_clock,
  input  logic                  out_clock,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  in_almost_full,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_almost_empty,
  output logic [DATA_WIDTH-1:0] out_data
);

  localparam int PW    = ADDR_WIDTH + 1;
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [PW-1:0] AFULL_LVL  = PW'(DEPTH - ALMOST_THRESHOLD);
  localparam logic [PW-1:0] AEMPTY_LVL = PW'(ALMOST_THRESHOLD);

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [PW-1:0] wbin_q, wbin_d, wgray_q, wgray_d, rsync1_q, rsync2_q, wocc;
  logic          full_q, full_d, afull_q, afull_d, wr_en;

  logic [PW-1:0] rbin_q, rbin_d, rgray_q, rgray_d, wsync1_q, wsync2_q, rocc;
  logic          empty_q, empty_d, aempty_q, aempty_d, rd_en;

  // Write domain: flags are evaluated against the post-write pointer so they never lag own writes.
  always_comb begin
    wr_en   = in_valid && !full_q;
    wbin_d  = wbin_q + PW'(wr_en);
    wgray_d = wbin_d ^ (wbin_d >> 1);
    wocc    = wbin_d - gray2bin(rsync2_q);
    full_d  = (wgray_d == {~rsync2_q[PW-1:PW-2], rsync2_q[PW-3:0]});
    afull_d = (wocc >= AFULL_LVL);
  end

  always_ff @(posedge in_clock or posedge reset) begin
    if (reset) begin
      wbin_q   <= '0;
      wgray_q  <= '0;
      rsync1_q <= '0;
      rsync2_q <= '0;
      full_q   <= 1'b0;
      afull_q  <= 1'b0;
    end else begin
      wbin_q   <= wbin_d;
      wgray_q  <= wgray_d;
      rsync1_q <= rgray_q;
      rsync2_q <= rsync1_q;
      full_q   <= full_d;
      afull_q  <= afull_d;
    end
  end

  always_ff @(posedge in_clock) begin
    if (wr_en) mem_q[wbin_q[ADDR_WIDTH-1:0]] <= in_data;
  end

  always_comb begin
    rd_en    = out_ready && !empty_q;
    rbin_d   = rbin_q + PW'(rd_en);
    rgray_d  = rbin_d ^ (rbin_d >> 1);
    rocc     = gray2bin(wsync2_q) - rbin_d;
    empty_d  = (rgray_d == wsync2_q);
    aempty_d = (rocc <= AEMPTY_LVL);
  end

  always_ff @(posedge out_clock or posedge reset) begin
    if (reset) begin
      rbin_q   <= '0;
      rgray_q  <= '0;
      wsync1_q <= '0;
      wsync2_q <= '0;
      empty_q  <= 1'b1;
      aempty_q <= 1'b1;
    end else begin
      rbin_q   <= rbin_d;
      rgray_q  <= rgray_d;
      wsync1_q <= wgray_q;
      wsync2_q <= wsync1_q;
      empty_q  <= empty_d;
      aempty_q <= aempty_d;
    end
  end

  assign in_ready         = !full_q;
  assign in_almost_full   = afull_q;
  assign out_valid        = !empty_q;
  assign out_almost_empty = aempty_q;
  assign out_data         = mem_q[rbin_q[ADDR_WIDTH-1:0]];

endmodule

// File: tb/tb_async_fifo.sv
// tb/tb_async_fifo.sv - bench for async_fifo: vector table, hand sequences, queue-model streams
module tb_async_fifo;
  localparam int DEPTH  = 16;
  localparam int THR    = 2;
  localparam int BUDGET = 20000;

  logic       in_clock = 1'b0, out_clock = 1'b0, reset = 1'b1;
  logic       in_valid = 1'b0, out_ready = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready, in_almost_full, out_valid, out_almost_empty;
  logic [7:0] out_data;

  int in_half = 10, out_half = 1;
  always #(in_half) in_clock = ~in_clock;
  always #(out_half) out_clock = ~out_clock;

  async_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .ALMOST_THRESHOLD(THR)) dut (
    .in_clock(in_clock), .out_clock(out_clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_almost_full(in_almost_full), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_almost_empty(out_almost_empty),
    .out_data(out_data)
  );

  int errors = 0, checks = 0;
  logic [7:0] model_q[$];

  typedef struct {
    logic [7:0] data;
    logic       ready_before;
    logic       afull_after;
    logic       ready_after;
  } vec_t;
  vec_t tab [17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic write_word(input logic [7:0] d);
    @(negedge in_clock);
    in_valid = 1'b1;
    in_data  = d;
    @(negedge in_clock);
    in_valid = 1'b0;
  endtask

  task automatic read_word();
    @(negedge out_clock);
    out_ready = 1'b1;
    @(negedge out_clock);
    out_ready = 1'b0;
  endtask

  // Producer and consumer run concurrently; every accepted word is checked in order against model_q.
  task automatic run_stream(input int n, input int vpct, input int rpct, input bit rnd,
                            input logic [7:0] base, output int stalls);
    int sent, got;
    sent = 0; got = 0; stalls = 0;
    fork
      begin
        int cyc = 0;
        bit pend = 1'b0;
        logic [7:0] d = base;
        while (sent < n && cyc < BUDGET) begin
          @(negedge in_clock);
          cyc++;
          if (pend) begin in_valid = 1'b0; pend = 1'b0; end
          if (!in_valid && $urandom_range(99) < vpct) begin
            in_valid = 1'b1;
            in_data  = rnd ? 8'($urandom) : d;
          end
          if (in_valid) begin
            if (in_ready) begin
              chk("ready_while_full", model_q.size() < DEPTH, 1);
              model_q.push_back(in_data);
              sent++; d++; pend = 1'b1;
            end else stalls++;
          end
        end
        @(negedge in_clock);
        in_valid = 1'b0;
        chk("producer_done", sent, n);
      end
      begin
        int cyc = 0;
        while (got < n && cyc < BUDGET) begin
          @(negedge out_clock);
          cyc++;
          out_ready = ($urandom_range(99) < rpct);
          if (out_valid && out_ready) begin
            chk("valid_backed_by_data", model_q.size() > 0, 1);
            if (model_q.size() > 0) begin
              chk("stream_data", out_data, model_q.pop_front());
              got++;
            end
          end
        end
        @(negedge out_clock);
        out_ready = 1'b0;
        chk("consumer_done", got, n);
      end
    join
  endtask

  initial begin
    int st;
    for (int i = 0; i < 17; i++) begin
      tab[i].data         = (i < 16) ? 8'(i) : 8'hFF;
      tab[i].ready_before = (i < DEPTH);
      tab[i].afull_after  = ((i + 1) >= DEPTH - THR);
      tab[i].ready_after  = ((i + 1) < DEPTH);
    end

    #5;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_aempty", out_almost_empty, 1);
    chk("rst_afull", in_almost_full, 0);
    #20 reset = 1'b0;
    repeat (4) @(negedge in_clock);
    chk("idle_in_ready", in_ready, 1);
    chk("idle_out_valid", out_valid, 0);
    chk("idle_aempty", out_almost_empty, 1);
    chk("idle_afull", in_almost_full, 0);

    // First-word latency: out_valid must be up by the 3rd out_clock edge after the write edge.
    @(negedge in_clock);
    in_valid = 1'b1;
    in_data  = 8'hAA;
    @(posedge in_clock);
    repeat (3) @(posedge out_clock);
    @(negedge out_clock);
    in_valid = 1'b0;
    chk("latency_out_valid", out_valid, 1);
    chk("head_aa", out_data, 8'hAA);
    write_word(8'hBB);
    repeat (4) @(negedge out_clock);
    chk("head_still_aa", out_data, 8'hAA);
    read_word();
    chk("valid_after_1st_read", out_valid, 1);
    chk("head_bb", out_data, 8'hBB);
    read_word();
    chk("empty_after_2nd_read", out_valid, 0);

    repeat (4) @(negedge in_clock);
    for (int i = 0; i < 17; i++) begin
      @(negedge in_clock);
      chk($sformatf("fill%0d_ready_before", i), in_ready, tab[i].ready_before);
      in_valid = 1'b1;
      in_data  = tab[i].data;
      @(negedge in_clock);
      in_valid = 1'b0;
      chk($sformatf("fill%0d_afull", i), in_almost_full, tab[i].afull_after);
      chk($sformatf("fill%0d_ready_after", i), in_ready, tab[i].ready_after);
    end
    repeat (4) @(negedge out_clock);
    for (int j = 0; j < 16; j++) begin
      @(negedge out_clock);
      chk($sformatf("drain%0d_valid", j), out_valid, 1);
      chk($sformatf("drain%0d_data", j), out_data, 8'(j));
      chk($sformatf("drain%0d_aempty", j), out_almost_empty, (16 - j) <= THR);
      out_ready = 1'b1;
      @(negedge out_clock);
      out_ready = 1'b0;
      if (j == 0) begin
        repeat (3) @(posedge in_clock);
        @(negedge in_clock);
        chk("space_latency_in_ready", in_ready, 1);
      end
    end
    chk("drained_no_ff", out_valid, 0);

    run_stream(40, 100, 100, 1'b0, 8'h20, st);

    in_half = 1; out_half = 10;
    repeat (4) @(negedge out_clock);
    run_stream(20, 100, 100, 1'b0, 8'h40, st);
    chk("producer_stalled", st > 0, 1);

    in_half = 3; out_half = 5;
    repeat (4) @(negedge out_clock);
    run_stream(200, 70, 60, 1'b1, 8'h00, st);
    chk("model_empty", model_q.size(), 0);

    in_half = 10; out_half = 1;
    repeat (4) @(negedge in_clock);
    for (int i = 0; i < 5; i++) write_word(8'(8'h10 + i));
    repeat (10) @(negedge out_clock);
    chk("queued_valid", out_valid, 1);
    @(negedge in_clock);
    #3 reset = 1'b1;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_aempty", out_almost_empty, 1);
    chk("midrst_afull", in_almost_full, 0);
    #4 reset = 1'b0;
    model_q.delete();
    write_word(8'h5A);
    repeat (5) @(negedge out_clock);
    chk("post_rst_valid", out_valid, 1);
    chk("post_rst_head", out_data, 8'h5A);
    read_word();
    chk("post_rst_empty", out_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
